bfloat_mac_drain: RTL and testbench
===================================

Name: bfloat_mac_drain

Overview:
- Result-side reader for the parameterized bfloat16 MAC array.
- Captures the packed 16*N-bit lane results on a capture strobe into one of two banks (ping-pong).
- Streams the captured lanes out one 16-bit word per beat over a valid/ready handshake, lane 0 first.
- Sits between the MAC array outputs and the downstream result consumer (memory writer or host FIFO).

Parameters:
- N, 2, number of bfloat16 lanes in res_in; legal range 1 or more.
- LANE_W, (N>1 ? $clog2(N) : 1), width of the lane index; derived, not overridden.

Ports:
- clk1  input  1  clock; all logic on its rising edge.
- rst1  input  1  synchronous reset, active-high.
- capture  input  1  one-cycle strobe; sample res_in this edge.
- res_in  input  16*N  packed MAC results; lane i = res_in[16*i+15:16*i].
- out_data  output  16  current bfloat16 word.
- out_lane  output  LANE_W  lane index of out_data.
- out_valid  output  1  out_data/out_lane/out_last valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high on the lane N-1 beat.
- busy  output  1  at least one bank holds undrained data.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Storage:
  - Two banks of 16*N bits, each with a full flag.
  - wr_ptr selects the bank for the next capture; rd_ptr selects the bank being drained.
  - A lane counter (LANE_W bits) tracks the drain position.
- Reset (rst1=1 at an edge): banks empty, wr_ptr=rd_ptr=0, lane=0; out_valid=0, out_last=0, out_lane=0, out_data=0, busy=0, overflow=0.
  - Reset mid-drain discards all banked data; no partial beats follow.
- Capture:
  - If capture=1 and bank[wr_ptr] is empty (or is freed this same edge), res_in is latched there, the bank is marked full and wr_ptr toggles.
  - If both banks are full and neither frees this edge, the capture is dropped and overflow sets to 1.
  - overflow clears only on reset.
- Drain FSM, two states:
  - IDLE: out_valid=0. Go to DRAIN when bank[rd_ptr] becomes full.
  - DRAIN: out_valid=1.
    - out_data = bank[rd_ptr] lane[lane]; out_lane = lane; out_last = (lane == N-1).
- Latency: capture at edge t gives out_valid=1 in the cycle after edge t, i.e. 1 cycle.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_lane and out_last hold stable.
  - out_valid never drops without a transfer.
- On transfer with lane < N-1: lane increments.
- On transfer with lane = N-1:
  - lane returns to 0, bank[rd_ptr] is freed, rd_ptr toggles.
  - If the other bank is full, stay in DRAIN with no bubble; otherwise go to IDLE.
- Simultaneous capture with last-beat transfer while both banks are full: the capture lands in the bank being freed. No overflow; the freed bank's old data was already sent.
- N=1: every beat has out_last=1 and out_lane=0.
- busy = OR of both full flags.
- No arithmetic on data; words pass bit-exact.

Optional Feature:
- Macro: DRAIN_NAN_FLAG_EN.
- Defined:
  - Adds output out_nan (1 bit), valid with out_valid.
  - out_nan = 1 when out_data[14:7] == 8'hFF and out_data[6:0] != 0.
  - Adds sticky output nan_seen, set on any transferred NaN beat and cleared by rst1.
  - Both reset to 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- N=2, capture with res_in=32'h4000_3F80, out_ready=1 -> next cycle out_data=16'h3F80, lane 0, last 0; following cycle 16'h4000, lane 1, last 1; then out_valid=0, busy=0.
- Backpressure: out_ready=0 for 5 cycles after capture -> out_valid=1 and out_data=16'h3F80 held stable; releasing ready drains both lanes in order.
- Back-to-back captures 32'h4000_3F80 then 32'hC000_BF80, ready=1 -> four consecutive beats 3F80, 4000, BF80, C000 with no bubble; overflow=0.
- out_ready=0, three captures -> third dropped, overflow=1 and stays 1; drain yields only the first two vectors. A capture on the lane-1 transfer edge with both banks full is accepted.
- rst1 asserted mid-drain after lane 0 transfer -> next cycle out_valid=0, busy=0, overflow=0; no further beats.
- DRAIN_NAN_FLAG_EN defined, res_in=32'h7FC0_3F80 -> out_nan 0 on lane 0, 1 on lane 1; nan_seen=1 until reset.

Source files
------------

// File: rtl/bfloat_mac_drain.sv
// Ping-pong capture of packed bfloat16 lane results, drained one word per beat over valid/ready.
// Optional DRAIN_NAN_FLAG_EN adds out_nan (per-beat NaN flag) and sticky nan_seen.
module bfloat_mac_drain #(
  parameter  int N      = 2,
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              capture,
  input  logic [16*N-1:0]   res_in,
  output logic [15:0]       out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
`ifdef DRAIN_NAN_FLAG_EN
  ,
  output logic              out_nan,
  output logic              nan_seen
`endif
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state;
  logic [16*N-1:0]     bank [2];
  logic [1:0]          full;
  logic [1:0]          free;
  logic [1:0]          full_next;
  logic                wr_ptr;
  logic                rd_ptr;
  logic                rd_ptr_next;
  logic [LANE_W-1:0]   lane;
  logic                xfer;
  logic                last_xfer;
  logic                cap_ok;

  // A bank freed by the last beat this edge may be refilled on the same edge.
  always_comb begin
    xfer        = (state == DRAIN) && out_ready;
    last_xfer   = xfer && (lane == LAST_LANE);
    free        = '0;
    free[rd_ptr] = last_xfer;
    cap_ok      = capture && (!full[wr_ptr] || free[wr_ptr]);
    full_next   = full & ~free;
    if (cap_ok) full_next[wr_ptr] = 1'b1;
    rd_ptr_next = rd_ptr ^ last_xfer;
  end

  always_ff @(posedge clk1) begin
    if (rst1) begin
      bank[0]  <= '0;
      bank[1]  <= '0;
      full     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      lane     <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      if (cap_ok) bank[wr_ptr] <= res_in;
      wr_ptr <= wr_ptr ^ cap_ok;
      full   <= full_next;
      rd_ptr <= rd_ptr_next;
      if (xfer) lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
      // Staying in DRAIN whenever the next bank to read is full gives back-to-back beats.
      state <= full_next[rd_ptr_next] ? DRAIN : IDLE;
      if (capture && !cap_ok) overflow <= 1'b1;
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = bank[rd_ptr][16*int'(lane) +: 16];
  assign out_lane  = lane;
  assign out_last  = out_valid && (lane == LAST_LANE);
  assign busy      = |full;

`ifdef DRAIN_NAN_FLAG_EN
  assign out_nan = out_valid && (out_data[14:7] == 8'hFF) && (out_data[6:0] != 7'd0);

  always_ff @(posedge clk1) begin
    if (rst1) nan_seen <= 1'b0;
    else if (xfer && out_nan) nan_seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bfloat_mac_drain.sv
// Self-checking bench for bfloat_mac_drain (N=2): vector table, corner-case sequences, random vs queue model.
module tb_bfloat_mac_drain;
  localparam int N = 2;

  logic        clk1 = 1'b0;
  logic        rst1;
  logic        capture;
  logic [31:0] res_in;
  logic [15:0] out_data;
  logic [0:0]  out_lane;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overflow;
`ifdef DRAIN_NAN_FLAG_EN
  logic        out_nan;
  logic        nan_seen;
`endif

  int checks = 0;
  int errors = 0;

  bfloat_mac_drain #(.N(N)) dut (
    .clk1(clk1), .rst1(rst1), .capture(capture), .res_in(res_in),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .overflow(overflow)
`ifdef DRAIN_NAN_FLAG_EN
    , .out_nan(out_nan), .nan_seen(nan_seen)
`endif
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [31:0] res;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1ns past it.
  task automatic cyc(input logic cap, input logic [31:0] r, input logic rdy);
    capture   = cap;
    res_in    = r;
    out_ready = rdy;
    @(posedge clk1);
    #1;
    capture = 1'b0;
  endtask

  task automatic chk_beat(input string name, input logic [15:0] d, input logic [31:0] ln, input logic lst);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".data"},  {16'd0, out_data}, {16'd0, d});
    chk({name, ".lane"},  {31'd0, out_lane}, ln);
    chk({name, ".last"},  {31'd0, out_last}, {31'd0, lst});
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".busy"},  {31'd0, busy}, 32'd0);
  endtask

  localparam logic [31:0] VA = 32'h4000_3F80;
  localparam logic [31:0] VB = 32'hC000_BF80;
  localparam logic [31:0] VC = 32'hDEAD_BEEF;
  localparam logic [31:0] VD = 32'h1234_5678;

  // Reference model: queue of captured vectors (at most two), plus read position in the head.
  logic [31:0] mq [$];
  int          mpos;
  logic        movf;

  initial begin
    tbl[0] = '{32'h4000_3F80, 16'h3F80, 16'h4000};
    tbl[1] = '{32'hC000_BF80, 16'hBF80, 16'hC000};
    tbl[2] = '{32'h0000_FFFF, 16'hFFFF, 16'h0000};
    tbl[3] = '{32'h7F80_0001, 16'h0001, 16'h7F80};

    rst1 = 1'b1; capture = 1'b0; res_in = '0; out_ready = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst.valid", {31'd0, out_valid}, 0);
    chk("rst.data",  {16'd0, out_data}, 0);
    chk("rst.lane",  {31'd0, out_lane}, 0);
    chk("rst.last",  {31'd0, out_last}, 0);
    chk("rst.busy",  {31'd0, busy}, 0);
    chk("rst.ovf",   {31'd0, overflow}, 0);
    rst1 = 1'b0;
    cyc(0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, tbl[i].res, 1);
      chk_beat($sformatf("tbl%0d.b0", i), tbl[i].w0, 0, 1'b0);
      cyc(0, 0, 1);
      chk_beat($sformatf("tbl%0d.b1", i), tbl[i].w1, 1, 1'b1);
      cyc(0, 0, 1);
      chk_idle($sformatf("tbl%0d.end", i));
    end

    // Backpressure holds the head beat stable.
    cyc(1, VA, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk_beat($sformatf("bp.hold%0d", i), 16'h3F80, 0, 1'b0);
    end
    cyc(0, 0, 1);
    chk_beat("bp.b1", 16'h4000, 1, 1'b1);
    cyc(0, 0, 1);
    chk_idle("bp.end");

    // Back-to-back captures drain with no bubble.
    cyc(1, VA, 1);
    chk_beat("b2b.0", 16'h3F80, 0, 1'b0);
    cyc(1, VB, 1);
    chk_beat("b2b.1", 16'h4000, 1, 1'b1);
    cyc(0, 0, 1);
    chk_beat("b2b.2", 16'hBF80, 0, 1'b0);
    cyc(0, 0, 1);
    chk_beat("b2b.3", 16'hC000, 1, 1'b1);
    chk("b2b.ovf", {31'd0, overflow}, 0);
    cyc(0, 0, 1);
    chk_idle("b2b.end");

    // Overflow, then a capture accepted on the edge that frees a bank.
    cyc(1, VA, 0);
    cyc(1, VB, 0);
    chk("ovf.noovf", {31'd0, overflow}, 0);
    cyc(1, VC, 0);
    chk("ovf.set", {31'd0, overflow}, 1);
    chk_beat("ovf.a0", 16'h3F80, 0, 1'b0);
    cyc(0, 0, 1);
    chk_beat("ovf.a1", 16'h4000, 1, 1'b1);
    cyc(1, VD, 1);
    chk_beat("ovf.b0", 16'hBF80, 0, 1'b0);
    cyc(0, 0, 1);
    chk_beat("ovf.b1", 16'hC000, 1, 1'b1);
    cyc(0, 0, 1);
    chk_beat("ovf.d0", 16'h5678, 0, 1'b0);
    cyc(0, 0, 1);
    chk_beat("ovf.d1", 16'h1234, 1, 1'b1);
    cyc(0, 0, 1);
    chk_idle("ovf.end");
    chk("ovf.sticky", {31'd0, overflow}, 1);

    // Reset mid-drain discards the rest.
    cyc(1, VA, 1);
    cyc(0, 0, 1);
    chk_beat("rmd.b1", 16'h4000, 1, 1'b1);
    rst1 = 1'b1;
    cyc(0, 0, 1);
    rst1 = 1'b0;
    chk_idle("rmd.rst");
    chk("rmd.ovf", {31'd0, overflow}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk_idle($sformatf("rmd.after%0d", i));
    end

`ifdef DRAIN_NAN_FLAG_EN
    cyc(1, 32'h7FC0_3F80, 1);
    chk_beat("nan.b0", 16'h3F80, 0, 1'b0);
    chk("nan.flag0", {31'd0, out_nan}, 0);
    chk("nan.seen0", {31'd0, nan_seen}, 0);
    cyc(0, 0, 1);
    chk("nan.flag1", {31'd0, out_nan}, 1);
    cyc(0, 0, 1);
    chk("nan.seen1", {31'd0, nan_seen}, 1);
    cyc(0, 0, 1);
    chk("nan.seen_hold", {31'd0, nan_seen}, 1);
    rst1 = 1'b1;
    cyc(0, 0, 0);
    rst1 = 1'b0;
    chk("nan.seen_rst", {31'd0, nan_seen}, 0);
`endif

    // Random traffic against the queue model.
    mpos = 0;
    movf = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic        cap;
      logic        rdy;
      logic [31:0] r;
      cap = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      r   = $urandom;
      if (mq.size() > 0 && rdy) begin
        if (mpos == N - 1) begin
          void'(mq.pop_front());
          mpos = 0;
        end else begin
          mpos++;
        end
      end
      if (cap) begin
        if (mq.size() < 2) mq.push_back(r);
        else movf = 1'b1;
      end
      cyc(cap, r, rdy);
      chk($sformatf("rnd%0d.valid", c), {31'd0, out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk($sformatf("rnd%0d.data", c), {16'd0, out_data}, {16'd0, mq[0][16*mpos +: 16]});
        chk($sformatf("rnd%0d.lane", c), {31'd0, out_lane}, mpos);
        chk($sformatf("rnd%0d.last", c), {31'd0, out_last}, {31'd0, mpos == N - 1});
      end
      chk($sformatf("rnd%0d.busy", c), {31'd0, busy}, {31'd0, mq.size() > 0});
      chk($sformatf("rnd%0d.ovf", c),  {31'd0, overflow}, {31'd0, movf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
